// File: rtl/bp_pkg.sv
// Branch-predictor shared types: 2-bit counters and BHT FSM states.
// Also used by the BTB for its taken input.
package bp_pkg;

   typedef logic [1:0] ctr2_t;

   localparam ctr2_t CTR_SNT = 2'b00;
   localparam ctr2_t CTR_WNT = 2'b01;
   localparam ctr2_t CTR_WT  = 2'b10;
   localparam ctr2_t CTR_ST  = 2'b11;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bht_state_t;

endpackage

// File: rtl/sat_ctr2.sv
// 2-bit saturating counter next-value logic.
// Shared by the table update path and the same-cycle bypass.
module sat_ctr2
   import bp_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   // Step toward the outcome, holding at either rail.
   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_history_table.sv
// 2-bit counter branch direction predictor with init sweep and bypass.
// Define BHT_GSHARE_EN for a gshare index; otherwise bimodal.
module branch_history_table
   import bp_pkg::*;
#(
   parameter int NUM_ENTRIES = 64,
   parameter int INDEX_BITS  = $clog2(NUM_ENTRIES),
   parameter int HIST_BITS   = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic [31:0]           pc,
   output logic [1:0]            taken,
   output logic [INDEX_BITS-1:0] pred_idx,
   output logic                  ready,
   input  logic                  upd_valid,
   input  logic [INDEX_BITS-1:0] upd_idx,
   input  logic                  upd_taken
);

   if (HIST_BITS > INDEX_BITS || HIST_BITS < 2) begin : g_bad_hist
      $error("HIST_BITS must be in 2..INDEX_BITS");
   end

   localparam logic [INDEX_BITS-1:0] LAST = INDEX_BITS'(NUM_ENTRIES - 1);

   bht_state_t            state_q, state_d;
   logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
   ctr2_t                 tbl_q [NUM_ENTRIES];

   logic                  init_we;
   logic                  upd_acc;
   ctr2_t                 upd_cur;
   ctr2_t                 upd_nxt;
   logic [INDEX_BITS-1:0] pc_idx;
   logic                  unused_pc;

   assign pc_idx    = pc[INDEX_BITS+1:2];
   assign unused_pc = ^{pc[31:INDEX_BITS+2], pc[1:0]};

`ifdef BHT_GSHARE_EN
   logic [HIST_BITS-1:0]  ghr_q, ghr_d;
   logic [INDEX_BITS-1:0] ghr_ext;

   // Zero-extend history up to the index width.
   always_comb begin
      ghr_ext                = '0;
      ghr_ext[HIST_BITS-1:0] = ghr_q;
   end

   assign pred_idx = pc_idx ^ ghr_ext;

   // Non-speculative history: shift in each accepted outcome.
   always_comb begin
      ghr_d = ghr_q;
      if (state_q == ST_RUN && clr) begin
         ghr_d = '0;
      end else if (upd_acc) begin
         ghr_d = {ghr_q[HIST_BITS-2:0], upd_taken};
      end
   end

   // History register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ghr_q <= '0;
      else      ghr_q <= ghr_d;
   end
`else
   assign pred_idx = pc_idx;
`endif

   // FSM next state: sweep in INIT, accept updates in RUN.
   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      init_we    = 1'b0;
      upd_acc    = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            init_we    = 1'b1;
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == LAST) begin
               state_d    = ST_RUN;
               init_ptr_d = '0;
            end
         end
         ST_RUN: begin
            if (clr) begin
               state_d    = ST_INIT;
               init_ptr_d = '0;
            end else begin
               upd_acc = upd_valid;
            end
         end
      endcase
   end

   // FSM state and sweep pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_INIT;
         init_ptr_q <= '0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
      end
   end

   assign upd_cur = tbl_q[upd_idx];

   sat_ctr2 u_sat (
      .ctr_i   (upd_cur),
      .taken_i (upd_taken),
      .ctr_o   (upd_nxt)
   );

   // Counter table: no reset, written by sweep or accepted update.
   always_ff @(posedge clk) begin
      if (init_we) begin
         tbl_q[init_ptr_q] <= CTR_WNT;
      end else if (upd_acc) begin
         tbl_q[upd_idx] <= upd_nxt;
      end
   end

   // Lookup with same-cycle bypass of an accepted update.
   always_comb begin
      taken = CTR_SNT;
      if (state_q == ST_RUN) begin
         if (upd_acc && upd_idx == pred_idx) taken = upd_nxt;
         else                                 taken = tbl_q[pred_idx];
      end
   end

   assign ready = (state_q == ST_RUN);

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table (64 entries).
// Scoreboard of per-cycle expected outputs plus spot checks.
module tb_branch_history_table;

   typedef struct packed {
      logic [1:0] tk;
      logic [5:0] idx;
      logic       rdy;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [31:0] pc;
   logic [1:0]  taken;
   logic [5:0]  pred_idx;
   logic        ready;
   logic        upd_valid;
   logic [5:0]  upd_idx;
   logic        upd_taken;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t       sb [$];
   logic [1:0] mt [64];
   logic [5:0] mghr;
   logic       mrdy;
   int         mcnt;

   always #5 clk = ~clk;

   branch_history_table dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .pc        (pc),
      .taken     (taken),
      .pred_idx  (pred_idx),
      .ready     (ready),
      .upd_valid (upd_valid),
      .upd_idx   (upd_idx),
      .upd_taken (upd_taken)
   );

   function automatic logic [1:0] nxt(logic [1:0] v, logic t);
      if (t) return (v == 2'b11) ? v : v + 2'd1;
      return (v == 2'b00) ? v : v - 2'd1;
   endfunction

   function automatic logic [5:0] midx(logic [31:0] p);
`ifdef BHT_GSHARE_EN
      return p[7:2] ^ mghr;
`else
      return p[7:2];
`endif
   endfunction

   function automatic logic [31:0] pc_for(logic [5:0] idx);
      logic [5:0] raw;
`ifdef BHT_GSHARE_EN
      raw = idx ^ mghr;
`else
      raw = idx;
`endif
      return {24'h0, raw, 2'b00};
   endfunction

   task automatic model_reset();
      mrdy = 1'b0;
      mcnt = 0;
      mghr = '0;
   endtask

   task automatic step(string tag);
      exp_t       e;
      logic [5:0] i;
      i     = midx(pc);
      e.rdy = mrdy;
      e.idx = i;
      if (!mrdy)
         e.tk = 2'b00;
      else if (upd_valid && !clr && upd_idx == i)
         e.tk = nxt(mt[i], upd_taken);
      else
         e.tk = mt[i];
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (ready !== e.rdy) begin
         n_fail++;
         $display("FAIL %s ready: got %b want %b", tag, ready, e.rdy);
      end
      n_checks++;
      if (pred_idx !== e.idx) begin
         n_fail++;
         $display("FAIL %s pred_idx: got %0d want %0d", tag, pred_idx, e.idx);
      end
      n_checks++;
      if (taken !== e.tk) begin
         n_fail++;
         $display("FAIL %s taken: got %b want %b", tag, taken, e.tk);
      end
      @(posedge clk);
      if (!rst) begin
         model_reset();
      end else if (!mrdy) begin
         mcnt++;
         if (mcnt == 64) begin
            mrdy = 1'b1;
            for (int k = 0; k < 64; k++) mt[k] = 2'b01;
         end
      end else if (clr) begin
         model_reset();
      end else if (upd_valid) begin
         mt[upd_idx] = nxt(mt[upd_idx], upd_taken);
         mghr        = {mghr[4:0], upd_taken};
      end
      #1;
   endtask

   task automatic idle();
      clr       = 1'b0;
      upd_valid = 1'b0;
      upd_idx   = '0;
      upd_taken = 1'b0;
   endtask

   task automatic sweep_wait(string tag);
      for (int k = 0; k < 64; k++) begin
         #1;
         n_checks++;
         if (ready !== 1'b0 || taken !== 2'b00) begin
            n_fail++;
            $display("FAIL %s sweep c%0d: ready=%b taken=%b want 0/00",
                     tag, k, ready, taken);
         end
         step(tag);
      end
      #1;
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready_rise: got %b want 1", tag, ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      pc  = 32'h0;
      idle();
      model_reset();
      #1;
      n_checks++;
      if (ready !== 1'b0 || taken !== 2'b00 || pred_idx !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_vals: ready=%b taken=%b idx=%0d want 0/00/0",
                  ready, taken, pred_idx);
      end
      step("reset");
      step("reset");
      rst = 1'b1;
      sweep_wait("init");
      for (int k = 0; k < 4; k++) begin
         pc = $urandom;
         #1;
         n_checks++;
         if (taken !== 2'b01) begin
            n_fail++;
            $display("FAIL init_val pc=%h: got %b want 01", pc, taken);
         end
         step("post_init");
      end
   endtask

   task automatic test_saturation();
      logic [1:0] want [7];
      want = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
      for (int k = 0; k < 7; k++) begin
         pc        = pc_for(6'd5);
         upd_valid = 1'b1;
         upd_idx   = 6'd5;
         upd_taken = (k < 3);
         #1;
         n_checks++;
         if (taken !== want[k]) begin
            n_fail++;
            $display("FAIL sat%0d: got %b want %b", k, taken, want[k]);
         end
         step("sat");
      end
      idle();
      pc = pc_for(6'd5);
      #1;
      n_checks++;
      if (taken !== 2'b00) begin
         n_fail++;
         $display("FAIL sat_hold: got %b want 00", taken);
      end
      step("sat_hold");
   endtask

   task automatic test_clr();
      pc        = pc_for(6'd7);
      clr       = 1'b1;
      upd_valid = 1'b1;
      upd_idx   = 6'd5;
      upd_taken = 1'b1;
      step("clr");
      idle();
      sweep_wait("clr_sweep");
      for (int k = 0; k < 64; k++) begin
         pc = pc_for(6'(k));
         #1;
         n_checks++;
         if (taken !== 2'b01 || pred_idx !== 6'(k)) begin
            n_fail++;
            $display("FAIL clr_entry%0d: taken=%b idx=%0d want 01/%0d",
                     k, taken, pred_idx, k);
         end
         step("clr_entry");
      end
      pc = 32'h14;
      #1;
      n_checks++;
      if (pred_idx !== 6'd5) begin
         n_fail++;
         $display("FAIL clr_ghr: idx=%0d want 5", pred_idx);
      end
      step("clr_ghr");
   endtask

   task automatic test_gshare();
`ifdef BHT_GSHARE_EN
      logic outc [3];
      outc = '{1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 3; k++) begin
         pc        = 32'h100;
         upd_valid = 1'b1;
         upd_idx   = 6'd10;
         upd_taken = outc[k];
         step("gs_upd");
      end
      idle();
      pc = 32'h14;
      #1;
      n_checks++;
      if (pred_idx !== 6'd3) begin
         n_fail++;
         $display("FAIL gshare_idx: got %0d want 3", pred_idx);
      end
      step("gs_idx");
`endif
   endtask

   task automatic test_bypass();
      pc        = pc_for(6'd5);
      upd_valid = 1'b1;
      upd_idx   = 6'd5;
      upd_taken = 1'b1;
      #1;
      n_checks++;
      if (taken !== 2'b10) begin
         n_fail++;
         $display("FAIL bypass: got %b want 10", taken);
      end
      step("bypass");
      idle();
      pc = pc_for(6'd5);
      #1;
      n_checks++;
      if (taken !== 2'b10) begin
         n_fail++;
         $display("FAIL bypass_next: got %b want 10", taken);
      end
      step("bypass_next");
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 40; k++) begin
         pc        = $urandom;
         upd_valid = ($urandom_range(0, 3) != 0);
         upd_idx   = ($urandom_range(0, 1) == 0) ? midx(pc) : 6'($urandom);
         upd_taken = $urandom_range(0, 1);
         step("b2b");
      end
      idle();
   endtask

   task automatic test_midsweep_reset();
      rst = 1'b0;
      model_reset();
      step("ms_rst");
      rst = 1'b1;
      for (int k = 0; k < 30; k++) step("ms_pre");
      rst = 1'b0;
      model_reset();
      step("ms_rst2");
      step("ms_rst2");
      rst = 1'b1;
      sweep_wait("ms_sweep");
      step("ms_run");
   endtask

   initial begin
      test_reset();
      test_saturation();
      test_clr();
      test_gshare();
      test_bypass();
      test_back_to_back();
      test_midsweep_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
